// File: rtl/vga_timing_gen.sv
// VGA raster timing generator.
// A pixel-rate divider steps a horizontal/vertical position counter; every
// output is decoded combinationally from those registers, so sync, blank and
// the active-area coordinates all describe the same pixel in the same cycle.
module vga_timing_gen #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter int   CLK_DIV  = 2,
    parameter logic SYNC_POL = 1'b0,
    parameter int   COL_W    = 10,
    parameter int   ROW_W    = 9,
    parameter int   FC_W     = 16
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             en,
    output logic             pix_en,
    output logic             HS,
    output logic             VS,
    output logic             blank,
    output logic [COL_W-1:0] col,
    output logic [ROW_W-1:0] row,
    output logic             line_start,
    output logic             frame_start,
    output logic [FC_W-1:0]  frame_count
);

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW    = (H_TOT > 1) ? $clog2(H_TOT) : 1;
    localparam int VW    = (V_TOT > 1) ? $clog2(V_TOT) : 1;
    localparam int DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    // One extra bit so the end of a sync pulse may equal H_TOT/V_TOT.
    localparam int HXW   = HW + 1;
    localparam int VXW   = VW + 1;

    localparam logic [DW-1:0]  DIV_LAST  = DW'(CLK_DIV - 1);
    localparam logic [HW-1:0]  H_LAST    = HW'(H_TOT - 1);
    localparam logic [VW-1:0]  V_LAST    = VW'(V_TOT - 1);
    localparam logic [HXW-1:0] H_ACT_X   = HXW'(H_ACTIVE);
    localparam logic [HXW-1:0] HS_BEG_X  = HXW'(H_ACTIVE + H_FP);
    localparam logic [HXW-1:0] HS_END_X  = HXW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VXW-1:0] V_ACT_X   = VXW'(V_ACTIVE);
    localparam logic [VXW-1:0] VS_BEG_X  = VXW'(V_ACTIVE + V_FP);
    localparam logic [VXW-1:0] VS_END_X  = VXW'(V_ACTIVE + V_FP + V_SYNC);

    logic [DW-1:0]  div_q;
    logic [HW-1:0]  h_q;
    logic [VW-1:0]  v_q;
    logic [HXW-1:0] h_x;
    logic [VXW-1:0] v_x;
    logic           hs_act;
    logic           vs_act;

    // Divider and raster position; reset wins over en, en=0 freezes everything.
    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            div_q       <= '0;
            h_q         <= '0;
            v_q         <= '0;
            frame_count <= '0;
        end else if (en) begin
            if (div_q == DIV_LAST) begin
                div_q <= '0;
                if (h_q == H_LAST) begin
                    h_q <= '0;
                    if (v_q == V_LAST) begin
                        v_q         <= '0;
                        frame_count <= frame_count + 1'b1;
                    end else begin
                        v_q <= v_q + 1'b1;
                    end
                end else begin
                    h_q <= h_q + 1'b1;
                end
            end else begin
                div_q <= div_q + 1'b1;
            end
        end
    end

    // Pixel strobe: the position advances on the edge that ends this cycle.
    assign pix_en      = en && (div_q == DIV_LAST);
    assign line_start  = pix_en && (h_q == '0);
    assign frame_start = line_start && (v_q == '0);

    // Zero-extended positions for range compares against the porch boundaries.
    assign h_x = {1'b0, h_q};
    assign v_x = {1'b0, v_q};

    // Sync windows and active-area decode.
    assign hs_act = (h_x >= HS_BEG_X) && (h_x < HS_END_X);
    assign vs_act = (v_x >= VS_BEG_X) && (v_x < VS_END_X);
    assign HS     = hs_act ? SYNC_POL : ~SYNC_POL;
    assign VS     = vs_act ? SYNC_POL : ~SYNC_POL;
    assign blank  = (h_x >= H_ACT_X) || (v_x >= V_ACT_X);

    // Coordinates are forced to zero outside the visible area.
    assign col = blank ? '0 : COL_W'(h_q);
    assign row = blank ? '0 : ROW_W'(v_q);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (default timing, default line with
// a short 8-line frame, and a tiny 7x5 raster) share clock, reset and en.
// A reference model predicts every output each cycle into a queue; the test
// tasks pop and compare, and add direct checks of sync widths and periods.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic reset;
    logic en;

    always #5 clk = ~clk;

    logic       d_pix_en, d_hs, d_vs, d_blank, d_ls, d_fs;
    logic [9:0] d_col;
    logic [8:0] d_row;
    logic [15:0] d_fc;
    logic       m_pix_en, m_hs, m_vs, m_blank, m_ls, m_fs;
    logic [9:0] m_col;
    logic [8:0] m_row;
    logic [15:0] m_fc;
    logic       s_pix_en, s_hs, s_vs, s_blank, s_ls, s_fs;
    logic [9:0] s_col;
    logic [8:0] s_row;
    logic [15:0] s_fc;

    vga_timing_gen dut_d (
        .CLOCK_50(clk), .reset(reset), .en(en), .pix_en(d_pix_en), .HS(d_hs), .VS(d_vs),
        .blank(d_blank), .col(d_col), .row(d_row), .line_start(d_ls), .frame_start(d_fs),
        .frame_count(d_fc));

    vga_timing_gen #(.V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)) dut_m (
        .CLOCK_50(clk), .reset(reset), .en(en), .pix_en(m_pix_en), .HS(m_hs), .VS(m_vs),
        .blank(m_blank), .col(m_col), .row(m_row), .line_start(m_ls), .frame_start(m_fs),
        .frame_count(m_fc));

    vga_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
                     .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
                     .CLK_DIV(1), .SYNC_POL(1'b1)) dut_s (
        .CLOCK_50(clk), .reset(reset), .en(en), .pix_en(s_pix_en), .HS(s_hs), .VS(s_vs),
        .blank(s_blank), .col(s_col), .row(s_row), .line_start(s_ls), .frame_start(s_fs),
        .frame_count(s_fc));

    logic [40:0] obs_d, obs_m, obs_s;
    assign obs_d = {d_pix_en, d_hs, d_vs, d_blank, d_col, d_row, d_ls, d_fs, d_fc};
    assign obs_m = {m_pix_en, m_hs, m_vs, m_blank, m_col, m_row, m_ls, m_fs, m_fc};
    assign obs_s = {s_pix_en, s_hs, s_vs, s_blank, s_col, s_row, s_ls, s_fs, s_fc};

    // Reset-state output vector with active-low sync.
    localparam logic [40:0] RST_OBS = {1'b0, 1'b1, 1'b1, 1'b0, 10'd0, 9'd0, 1'b0, 1'b0, 16'd0};

    // Timing of the three instances: 0 = dut_d, 1 = dut_m, 2 = dut_s.
    int   P_HA [3] = '{640, 640, 4};
    int   P_HFP[3] = '{16, 16, 1};
    int   P_HSW[3] = '{96, 96, 1};
    int   P_HBP[3] = '{48, 48, 1};
    int   P_VA [3] = '{480, 4, 2};
    int   P_VFP[3] = '{10, 1, 1};
    int   P_VSW[3] = '{2, 2, 1};
    int   P_VBP[3] = '{33, 1, 1};
    int   P_DIV[3] = '{2, 2, 1};
    logic P_POL[3] = '{1'b0, 1'b0, 1'b1};

    int md[3] = '{0, 0, 0};
    int mh[3] = '{0, 0, 0};
    int mv[3] = '{0, 0, 0};
    int mfc[3] = '{0, 0, 0};

    logic [40:0] q[$];
    int mon = 0;
    int n_cmp = 0;
    int n_err = 0;

    function automatic logic [40:0] model_out(int i);
        logic pe, hs, vs, bl, ls, fs;
        logic [9:0] c;
        logic [8:0] r;
        logic [15:0] f;
        int hb, vb;
        hb = P_HA[i] + P_HFP[i];
        vb = P_VA[i] + P_VFP[i];
        pe = en && (md[i] == P_DIV[i] - 1);
        hs = (mh[i] >= hb && mh[i] < hb + P_HSW[i]) ? P_POL[i] : ~P_POL[i];
        vs = (mv[i] >= vb && mv[i] < vb + P_VSW[i]) ? P_POL[i] : ~P_POL[i];
        bl = (mh[i] >= P_HA[i]) || (mv[i] >= P_VA[i]);
        c  = bl ? 10'd0 : 10'(mh[i]);
        r  = bl ? 9'd0 : 9'(mv[i]);
        ls = pe && (mh[i] == 0);
        fs = ls && (mv[i] == 0);
        f  = 16'(mfc[i]);
        return {pe, hs, vs, bl, c, r, ls, fs, f};
    endfunction

    // Advance one clock: update the model from the inputs seen at the edge and
    // push the prediction for the monitored instance.
    task automatic step();
        int ht, vt;
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            ht = P_HA[i] + P_HFP[i] + P_HSW[i] + P_HBP[i];
            vt = P_VA[i] + P_VFP[i] + P_VSW[i] + P_VBP[i];
            if (!reset) begin
                md[i] = 0; mh[i] = 0; mv[i] = 0; mfc[i] = 0;
            end else if (en) begin
                if (md[i] == P_DIV[i] - 1) begin
                    md[i] = 0;
                    if (mh[i] == ht - 1) begin
                        mh[i] = 0;
                        if (mv[i] == vt - 1) begin
                            mv[i] = 0;
                            mfc[i] = (mfc[i] + 1) % 65536;
                        end else begin
                            mv[i] = mv[i] + 1;
                        end
                    end else begin
                        mh[i] = mh[i] + 1;
                    end
                end else begin
                    md[i] = md[i] + 1;
                end
            end
        end
        #1;
        q.push_back(model_out(mon));
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        logic [40:0] e;
        int first;
        mon = 0;
        en = 1'b1;
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            e = q.pop_front();
            n_cmp++;
            if (obs_d !== e) begin
                n_err++;
                $display("FAIL reset_model k=%0d got %h want %h", k, obs_d, e);
            end
        end
        n_cmp++;
        if (obs_d !== RST_OBS) begin
            n_err++;
            $display("FAIL reset_values got %h want %h", obs_d, RST_OBS);
        end
        reset = 1'b1;
        first = -1;
        for (int k = 1; k <= 4; k++) begin
            step();
            e = q.pop_front();
            n_cmp++;
            if (obs_d !== e) begin
                n_err++;
                $display("FAIL release_model k=%0d got %h want %h", k, obs_d, e);
            end
            if (d_pix_en && first < 0) first = k;
        end
        // Strobe is up after the first edge, so the position moves on the second.
        n_cmp++;
        if (first !== 1) begin
            n_err++;
            $display("FAIL first_pix_en got cycle %0d want 1", first);
        end
    endtask

    task automatic test_line();
        logic [40:0] e;
        int hs_cnt, hs_first, bl_cnt, bl_first;
        mon = 0;
        en = 1'b1;
        do_reset();
        e = q.pop_front();
        n_cmp++;
        if (obs_d !== e) begin
            n_err++;
            $display("FAIL line_reset got %h want %h", obs_d, e);
        end
        hs_cnt = 0; hs_first = -1; bl_cnt = 0; bl_first = -1;
        for (int k = 1; k <= 1600; k++) begin
            step();
            e = q.pop_front();
            n_cmp++;
            if (obs_d !== e) begin
                n_err++;
                $display("FAIL line_model k=%0d got %h want %h", k, obs_d, e);
            end
            if (d_hs === 1'b0) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = mh[0];
            end
            if (d_blank === 1'b1) begin
                bl_cnt++;
                if (bl_first < 0) bl_first = mh[0];
            end
        end
        n_cmp++;
        if (hs_cnt != 192 || hs_first != 656) begin
            n_err++;
            $display("FAIL hsync_width got %0d clks from h=%0d want 192 from 656", hs_cnt, hs_first);
        end
        n_cmp++;
        if (bl_cnt != 320 || bl_first != 640) begin
            n_err++;
            $display("FAIL hblank_width got %0d clks from h=%0d want 320 from 640", bl_cnt, bl_first);
        end
    endtask

    task automatic test_pause();
        logic [40:0] e;
        int k, ls1, ls2;
        bit paused;
        mon = 0;
        en = 1'b1;
        do_reset();
        e = q.pop_front();
        n_cmp++;
        if (obs_d !== e) begin
            n_err++;
            $display("FAIL pause_reset got %h want %h", obs_d, e);
        end
        k = 0; ls1 = -1; ls2 = -1; paused = 1'b0;
        for (int n = 0; n < 4000 && ls2 < 0; n++) begin
            step();
            k++;
            e = q.pop_front();
            n_cmp++;
            if (obs_d !== e) begin
                n_err++;
                $display("FAIL pause_model k=%0d got %h want %h", k, obs_d, e);
            end
            if (d_ls === 1'b1) begin
                if (ls1 < 0) ls1 = k;
                else ls2 = k;
            end
            if (!paused && mh[0] == 300 && md[0] == 0) begin
                en = 1'b0;
                for (int j = 0; j < 37; j++) begin
                    step();
                    k++;
                    e = q.pop_front();
                    n_cmp++;
                    if (obs_d !== e || {d_pix_en, d_col} !== {1'b0, 10'd300}) begin
                        n_err++;
                        $display("FAIL pause_hold j=%0d got %h want %h col 300 pix_en 0", j, obs_d, e);
                    end
                end
                en = 1'b1;
                paused = 1'b1;
            end
        end
        n_cmp++;
        if (ls1 < 0 || ls2 < 0 || (ls2 - ls1) != 1637) begin
            n_err++;
            $display("FAIL paused_line_len got %0d clks want 1637", ls2 - ls1);
        end
    endtask

    task automatic test_frames();
        logic [40:0] e;
        int vs_cnt, vs_first, fs1, fs2, fs_n;
        mon = 1;
        en = 1'b1;
        do_reset();
        e = q.pop_front();
        n_cmp++;
        if (obs_m !== e) begin
            n_err++;
            $display("FAIL frames_reset got %h want %h", obs_m, e);
        end
        vs_cnt = 0; vs_first = -1; fs1 = -1; fs2 = -1; fs_n = 0;
        for (int k = 1; k <= 25600; k++) begin
            step();
            e = q.pop_front();
            n_cmp++;
            if (obs_m !== e) begin
                n_err++;
                $display("FAIL frames_model k=%0d got %h want %h", k, obs_m, e);
            end
            if (m_vs === 1'b0) begin
                vs_cnt++;
                if (vs_first < 0) vs_first = mv[1];
            end
            if (m_fs === 1'b1) begin
                fs_n++;
                if (fs1 < 0) fs1 = k;
                else if (fs2 < 0) fs2 = k;
            end
            if (k == 12799 || k == 12800) begin
                n_cmp++;
                if (m_fc !== ((k == 12800) ? 16'd1 : 16'd0)) begin
                    n_err++;
                    $display("FAIL frame_count_wrap k=%0d got %0d want %0d", k, m_fc, (k == 12800) ? 1 : 0);
                end
            end
        end
        // Two sync lines of 800 pixels at 2 clocks each, over two frames.
        n_cmp++;
        if (vs_cnt != 6400 || vs_first != 5) begin
            n_err++;
            $display("FAIL vsync_width got %0d clks from v=%0d want 6400 from 5", vs_cnt, vs_first);
        end
        n_cmp++;
        if (fs_n != 2 || (fs2 - fs1) != 12800) begin
            n_err++;
            $display("FAIL frame_period got %0d pulses period %0d want 2 period 12800", fs_n, fs2 - fs1);
        end
        n_cmp++;
        if (m_fc !== 16'd2) begin
            n_err++;
            $display("FAIL frame_count_end got %0d want 2", m_fc);
        end
    endtask

    task automatic test_midframe_reset();
        logic [40:0] e;
        bit found;
        mon = 1;
        en = 1'b1;
        found = 1'b0;
        for (int n = 0; n < 20000 && !found; n++) begin
            step();
            e = q.pop_front();
            n_cmp++;
            if (obs_m !== e) begin
                n_err++;
                $display("FAIL mid_model n=%0d got %h want %h", n, obs_m, e);
            end
            if (mv[1] == 5 && mh[1] == 400) found = 1'b1;
        end
        n_cmp++;
        if (!found || m_fc !== 16'd2) begin
            n_err++;
            $display("FAIL mid_precondition got found=%0d fc=%0d want 1 and 2", found, m_fc);
        end
        reset = 1'b0;
        step();
        reset = 1'b1;
        e = q.pop_front();
        n_cmp++;
        if (obs_m !== e || obs_m !== RST_OBS) begin
            n_err++;
            $display("FAIL mid_reset_values got %h want %h", obs_m, RST_OBS);
        end
        step();
        e = q.pop_front();
        n_cmp++;
        if (obs_m !== e || {m_pix_en, m_fs} !== 2'b11) begin
            n_err++;
            $display("FAIL mid_new_frame got %h want %h with frame_start", obs_m, e);
        end
    endtask

    task automatic test_small();
        logic [40:0] e;
        int fs1, fs2;
        mon = 2;
        en = 1'b0;
        do_reset();
        e = q.pop_front();
        n_cmp++;
        if (obs_s !== e) begin
            n_err++;
            $display("FAIL small_reset got %h want %h", obs_s, e);
        end
        en = 1'b1;
        fs1 = -1; fs2 = -1;
        for (int k = 1; k <= 70; k++) begin
            step();
            e = q.pop_front();
            n_cmp++;
            if (obs_s !== e || s_hs !== (mh[2] == 5) || s_vs !== (mv[2] == 3)) begin
                n_err++;
                $display("FAIL small_model k=%0d h=%0d v=%0d got %h want %h", k, mh[2], mv[2], obs_s, e);
            end
            if (s_fs === 1'b1) begin
                if (fs1 < 0) fs1 = k;
                else if (fs2 < 0) fs2 = k;
            end
        end
        n_cmp++;
        if (fs1 < 0 || fs2 < 0 || (fs2 - fs1) != 35) begin
            n_err++;
            $display("FAIL small_frame_period got %0d want 35", fs2 - fs1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        en = 1'b1;
        test_reset();
        test_line();
        test_pause();
        test_frames();
        test_midframe_reset();
        test_small();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
